uart_word_tx: RTL

UART transmitter that serialises 32-bit words from the CPU side onto a single TX line as four 8N1 bytes, least-significant byte first. It is the transmit counterpart of the CPU's UART receive path. It lets the core stream data-memory contents, such as the count value, back to a host. A ready/valid handshake is used on the word side and the uart_tx pin is registered on the pad side.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_word_tx_if.sv | 15 +
 rtl/uart_tx_byte.sv | 105 ++++++++++
 rtl/uart_word_tx.sv | 68 ++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding and line levels, common to
// the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam logic UART_IDLE      = 1'b1;
    localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_word_tx_if.sv
// Word-side handshake between a producer (master) and the word transmitter (slave).
interface uart_word_tx_if #(
    parameter int WORD_W = 32
);
    // A transfer happens on the rising edge where word_valid && word_ready are
    // both high; the producer holds word_valid and word_data stable until then,
    // and word_ready never depends on word_valid.
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (output word_valid, output word_data, input word_ready);
    modport slave  (input word_valid, input word_data, output word_ready);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte framer: start bit, eight data bits LSB first, stop bit, with a
// baud counter; tx is registered and lags the state register by one cycle.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx,
    output tx_state_t  state
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

    tx_state_t     state_n;
    logic [CW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    data_q, data_n;
    logic          tx_n;
    logic          baud_end;

    assign baud_end = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
            tx       <= UART_IDLE;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            data_q   <= data_n;
            tx       <= tx_n;
        end
    end

    always_comb begin
        state_n    = state;
        baud_n     = baud_cnt;
        bit_n      = bit_idx;
        data_n     = data_q;
        tx_n       = UART_IDLE;
        byte_ready = 1'b0;
        case (state)
            IDLE: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_n = START;
                    baud_n  = '0;
                    data_n  = byte_data;
                end
            end
            START: begin
                tx_n = UART_START_BIT;
                if (baud_end) begin
                    state_n = DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                end else begin
                    baud_n = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                tx_n = data_q[bit_idx];
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_idx == BIT_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud_cnt + CW'(1);
                end
            end
            STOP: begin
                tx_n = UART_STOP_BIT;
                // Ready in the final stop-bit cycle so the next byte follows with no gap.
                if (baud_end) begin
                    byte_ready = 1'b1;
                    baud_n     = '0;
                    if (byte_valid) begin
                        state_n = START;
                        data_n  = byte_data;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word transmitter: accepts a word on the ready/valid handshake and sends it
// as BYTES_PER_WORD back-to-back 8N1 frames, least-significant byte first.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 87,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic         clk,
    input  logic         reset,
    uart_word_tx_if.slave word,
    output logic         uart_tx,
    output logic         busy
);

    localparam int            WORD_W   = 8 * BYTES_PER_WORD;
    localparam int            IW       = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(BYTES_PER_WORD - 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_word_tx: CLKS_PER_BIT must be at least 2");
    end

    tx_state_t         byte_state;
    logic              byte_valid;
    logic              byte_ready;
    logic [7:0]        byte_data;
    logic              hs;
    logic              last_byte;
    logic              stop_end;
    // Bytes still to be sent; the next one always sits in [7:0].
    logic [WORD_W-1:0] pending;
    logic [IW-1:0]     byte_idx;

    assign word.word_ready = (byte_state == IDLE);
    assign busy            = (byte_state != IDLE);
    assign hs              = word.word_valid && word.word_ready;
    assign last_byte       = (byte_idx == IDX_LAST);
    assign stop_end        = byte_ready && (byte_state == STOP);
    assign byte_valid      = hs || (busy && !last_byte);
    assign byte_data       = hs ? word.word_data[7:0] : pending[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            byte_idx <= '0;
        end else if (hs) begin
            pending  <= word.word_data >> 8;
            byte_idx <= '0;
        end else if (stop_end && !last_byte) begin
            pending  <= pending >> 8;
            byte_idx <= byte_idx + IW'(1);
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .tx        (uart_tx),
        .state     (byte_state)
    );

endmodule
